// File: rtl/zbuf_pkg.sv
// Constants and types shared between the pixel FIFOs and the contention tree.
package zbuf_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;
  localparam int unsigned LENGTH      = 8;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    HOLD
  } fifo_state_t;

endpackage

// File: rtl/pixel_fifo_if.sv
// Write/request/ack bundle between a rasterizer lane, its pixel FIFO and the contention tree.
interface pixel_fifo_if #(
  parameter int unsigned LENGTH      = zbuf_pkg::LENGTH,
  parameter int unsigned PIXEL_WIDTH = zbuf_pkg::PIXEL_WIDTH
);

  logic                   wr_en;
  logic [PIXEL_WIDTH-1:0] pix_in;
  logic                   full;
  logic                   overflow;
  logic                   req;
  logic                   ack;
  logic [PIXEL_WIDTH-1:0] pix_out;
  logic [LENGTH-1:0]      fill;

  modport master (
    output wr_en, pix_in, req,
    input  full, overflow, ack, pix_out, fill
  );

  modport slave (
    input  wr_en, pix_in, req,
    output full, overflow, ack, pix_out, fill
  );

endinterface

// File: rtl/fifo_mem.sv
// Pixel storage array: one write port, one registered read port that holds between reads.
module fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Same-address write and read returns the old entry (pop and push when full).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_fifo.sv
// Per-lane pixel buffer: publishes occupancy on fill and answers each req assertion with
// exactly one ack pulse carrying one pixel.
module pixel_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LENGTH      = zbuf_pkg::LENGTH,
  parameter int unsigned PIXEL_WIDTH = zbuf_pkg::PIXEL_WIDTH
) (
  input logic         clk,
  input logic         rst,
  pixel_fifo_if.slave bus
);

  import zbuf_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LENGTH-1:0] FullFill = LENGTH'(DEPTH);

  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LENGTH-1:0]      fill_q, fill_d;
  logic                   full_q, overflow_q, ack_q;
  logic                   pop, wr_ok;
  logic [PIXEL_WIDTH-1:0] pix_q;
  fifo_state_t            state_q;

  // A pop in the same edge frees a slot, so a write while full is still accepted then.
  always_comb begin
    pop    = (state_q == IDLE) && bus.req && (fill_q != '0);
    wr_ok  = bus.wr_en && (!full_q || pop);
    fill_d = fill_q + LENGTH'(wr_ok) - LENGTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fill_q <= fill_d;
      full_q <= (fill_d == FullFill);
      if (bus.wr_en && !wr_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q <= HOLD;
          ack_q   <= 1'b0;
        end
        HOLD: begin
          ack_q <= 1'b0;
          if (!bus.req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(PIXEL_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr_q),
    .wr_data(bus.pix_in),
    .rd_en  (pop),
    .rd_addr(rd_ptr_q),
    .rd_data(pix_q)
  );

  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.ack      = ack_q;
  assign bus.pix_out  = pix_q;
  assign bus.fill     = fill_q;

endmodule

// File: tb/tb_pixel_fifo.sv
// Self-checking bench for pixel_fifo: vector table, directed corner sequences and a random
// phase compared against a queue-based model.
module tb_pixel_fifo;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pixel_fifo_if #(.LENGTH(8), .PIXEL_WIDTH(8)) bus ();

  pixel_fifo #(
    .DEPTH      (DEPTH),
    .LENGTH     (8),
    .PIXEL_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: contents as a queue, plus whether the current req assertion is served.
  logic [7:0] m_q[$];
  logic       m_ovf, m_ack, m_armed;
  logic [7:0] m_pix;

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] p;
    logic       q;
    int         e_fill;
    logic       e_full;
    logic       e_ovf;
    logic       e_ack;
    logic [7:0] e_pix;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [7:0] p, input logic q);
    logic pop;
    if (r) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_ack   = 1'b0;
      m_pix   = 8'h00;
      m_armed = 1'b1;
    end else begin
      pop = m_armed && q && (m_q.size() > 0);
      if (pop) begin
        m_pix   = m_q.pop_front();
        m_armed = 1'b0;
      end else if (!m_ack && !q) begin
        m_armed = 1'b1;
      end
      m_ack = pop;
      if (w) begin
        if (m_q.size() < DEPTH) m_q.push_back(p);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] p, input logic q);
    rst        = r;
    bus.wr_en  = w;
    bus.pix_in = p;
    bus.req    = q;
    @(posedge clk);
    model_edge(r, w, p, q);
    #1;
    check("model_fill", 32'(bus.fill), 32'(m_q.size()));
    check("model_full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    check("model_ack", 32'(bus.ack), 32'(m_ack));
    check("model_pix_out", 32'(bus.pix_out), 32'(m_pix));
  endtask

  task automatic add(input logic r, input logic w, input logic [7:0] p, input logic q,
                     input int f, input logic fu, input logic o, input logic a,
                     input logic [7:0] px);
    vec_t v;
    v.r = r; v.w = w; v.p = p; v.q = q;
    v.e_fill = f; v.e_full = fu; v.e_ovf = o; v.e_ack = a; v.e_pix = px;
    vecs.push_back(v);
  endtask

  task automatic fill_up(input logic [7:0] base);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, base + 8'(i), 1'b0);
    check("fill_16", 32'(bus.fill), 32'd16);
    check("full_at_16", 32'(bus.full), 32'd1);
  endtask

  // One complete handshake from IDLE: req edge, then two low edges back to IDLE.
  task automatic pull(input string name, input logic [7:0] exp);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check({name, "_ack"}, 32'(bus.ack), 32'd1);
    check({name, "_pix"}, 32'(bus.pix_out), 32'(exp));
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic r, w, q;

    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.pix_in = 8'h00;
    bus.req = 1'b0;

    // Reset, three writes, one pixel per long req, second req after a drop.
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'h11, 0, 1, 0, 0, 0, 8'h00);
    add(0, 1, 8'h22, 0, 2, 0, 0, 0, 8'h00);
    add(0, 1, 8'h33, 0, 3, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 2, 0, 0, 1, 8'h11);
    for (int i = 0; i < 9; i++) add(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h11);
    add(0, 0, 8'h00, 0, 2, 0, 0, 0, 8'h11);
    add(0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h22);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h22);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h22);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].w, vecs[i].p, vecs[i].q);
      check($sformatf("vec%0d_fill", i), 32'(bus.fill), 32'(vecs[i].e_fill));
      check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_ack", i), 32'(bus.ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_pix", i), 32'(bus.pix_out), 32'(vecs[i].e_pix));
    end

    // Write while full is dropped and sticks overflow; drain keeps order.
    fill_up(8'h40);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_fill", 32'(bus.fill), 32'd16);
    for (int i = 0; i < DEPTH; i++) pull($sformatf("drain%0d", i), 8'h40 + 8'(i));
    check("drain_empty", 32'(bus.fill), 32'd0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Pop and write in the same edge while full.
    fill_up(8'h60);
    step(1'b0, 1'b1, 8'hBB, 1'b1);
    check("popwr_ack", 32'(bus.ack), 32'd1);
    check("popwr_pix", 32'(bus.pix_out), 32'h60);
    check("popwr_fill", 32'(bus.fill), 32'd16);
    check("popwr_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i < DEPTH; i++) pull($sformatf("popwr%0d", i), 8'h60 + 8'(i));
    pull("popwr_last", 8'hBB);

    // Request while empty waits, then serves a later write.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("empty_noack", 32'(bus.ack), 32'd0);
    end
    step(1'b0, 1'b1, 8'h5C, 1'b1);
    check("late_wr_noack", 32'(bus.ack), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("late_ack", 32'(bus.ack), 32'd1);
    check("late_pix", 32'(bus.pix_out), 32'h5C);

    // Reset during the ACK cycle.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("pre_rst_ack", 32'(bus.ack), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_fill", 32'(bus.fill), 32'd0);
    check("rst_pix", 32'(bus.pix_out), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("post_rst_noack", 32'(bus.ack), 32'd0);
    end

    // Random traffic against the model.
    q = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 2) == 0) q = ~q;
      step(r, w, 8'($urandom), q);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
